// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared types and constants for the register-bus arbiter
package reg_bus_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  localparam logic [7:0] STALL_MAX = 8'd255;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } reg_cmd_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val == STALL_MAX) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/reg_cmd_fifo.sv
// rtl/reg_cmd_fifo.sv - in-order command queue for the low-priority register master
module reg_cmd_fifo
  import reg_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  reg_cmd_t      push_cmd,
  input  logic          pop,
  output reg_cmd_t      head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  reg_cmd_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic do_push;
  logic do_pop;

  // Guard here as well so a careless caller can never corrupt the level.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; only entries behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

endmodule

// File: rtl/reg_bus_arb.sv
// rtl/reg_bus_arb.sv - shares the register-file port between the SPI decoder and a queued local agent
module reg_bus_arb #(
  parameter int ADDR_W = reg_bus_pkg::ADDR_W,
  parameter int DATA_W = reg_bus_pkg::DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m0_read,
  input  logic                       m0_write,
  input  logic [ADDR_W-1:0]          m0_addr,
  input  logic [DATA_W-1:0]          m0_wdata,
  output logic [DATA_W-1:0]          m0_rdata,
  input  logic                       m1_valid,
  output logic                       m1_ready,
  input  logic                       m1_we,
  input  logic [ADDR_W-1:0]          m1_addr,
  input  logic [DATA_W-1:0]          m1_wdata,
  output logic                       m1_rvalid,
  output logic [DATA_W-1:0]          m1_rdata,
  output logic [$clog2(DEPTH+1)-1:0] m1_level,
  output logic [7:0]                 stall_cnt,
  output logic                       err_m0_rw,
  output logic                       reg_read,
  output logic                       reg_write,
  output logic [ADDR_W-1:0]          reg_addr,
  output logic [DATA_W-1:0]          reg_wdata,
  input  logic [DATA_W-1:0]          reg_rdata
);

  import reg_bus_pkg::*;

  logic     m0_act;
  logic     m0_both;
  logic     m1_issue;
  logic     m1_rd_issue;
  logic     q_full;
  logic     q_empty;
  reg_cmd_t q_head;
  reg_cmd_t q_in;

  // A double strobe is treated as no m0 access at all, freeing the bus for m1.
  assign m0_act   = m0_read ^ m0_write;
  assign m0_both  = m0_read & m0_write;
  assign m0_rdata = reg_rdata;

  assign m1_issue    = !m0_act && !q_empty;
  assign m1_rd_issue = m1_issue && !q_head.we;
  assign m1_ready    = !q_full;

  assign q_in.we    = m1_we;
  assign q_in.addr  = m1_addr;
  assign q_in.wdata = m1_wdata;

  reg_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (m1_valid && m1_ready),
    .push_cmd (q_in),
    .pop      (m1_issue),
    .head     (q_head),
    .level    (m1_level),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_comb begin
    reg_read  = 1'b0;
    reg_write = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    if (m0_act) begin
      reg_read  = m0_read;
      reg_write = m0_write;
      reg_addr  = m0_addr;
      reg_wdata = m0_wdata;
    end else if (m1_issue) begin
      reg_read  = !q_head.we;
      reg_write = q_head.we;
      reg_addr  = q_head.addr;
      reg_wdata = q_head.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      stall_cnt <= '0;
      err_m0_rw <= 1'b0;
    end else begin
      m1_rvalid <= m1_rd_issue;
      if (m1_rd_issue) begin
        m1_rdata <= reg_rdata;
      end
      if (m0_act && !q_empty) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      err_m0_rw <= m0_both;
    end
  end

endmodule

// File: doc/reg_bus_arb.md
# reg_bus_arb

Shares the single register-file port (read/write/addr/data into `regs`) between two masters. Master 0 is the SPI instruction decoder: single-cycle read/write pulses, no stall capability, absolute priority. Master 1 is a local on-chip agent (PWM configuration sequencer); its commands are buffered in a small in-order queue and issued whenever master 0 leaves the bus idle.

## Interface

Parameters:
- `ADDR_W`, default 6: register address width.
- `DATA_W`, default 8: register data width.
- `DEPTH`, default 4: master-1 command queue entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `m0_read`  in  1  master-0 read strobe, one cycle.
- `m0_write`  in  1  master-0 write strobe, one cycle.
- `m0_addr`  in  ADDR_W  master-0 address.
- `m0_wdata`  in  DATA_W  master-0 write data.
- `m0_rdata`  out  DATA_W  equals `reg_rdata`, combinational, same cycle.
- `m1_valid`  in  1  master-1 command valid.
- `m1_ready`  out  1  queue can accept a command.
- `m1_we`  in  1  1 = write, 0 = read.
- `m1_addr`  in  ADDR_W  master-1 address.
- `m1_wdata`  in  DATA_W  master-1 write data.
- `m1_rvalid`  out  1  one-cycle pulse; `m1_rdata` is valid.
- `m1_rdata`  out  DATA_W  registered read data for master 1.
- `m1_level`  out  $clog2(DEPTH+1)  number of queued commands.
- `stall_cnt`  out  8  saturating count of cycles the queue head was blocked by master 0.
- `err_m0_rw`  out  1  registered pulse; `m0_read` and `m0_write` were both high.
- `reg_read`  out  1  read strobe to `regs`.
- `reg_write`  out  1  write strobe to `regs`.
- `reg_addr`  out  ADDR_W  address to `regs`.
- `reg_wdata`  out  DATA_W  write data to `regs`.
- `reg_rdata`  in  DATA_W  combinational read data from `regs`.

## Operation

- **m0 active (`m0_act`):** `m0_act` = `m0_read` XOR `m0_write`.
  - If `m0_act` is high, `reg_*` mirror the m0 inputs combinationally.
  - If both strobes are high, nothing is issued to `regs`. `err_m0_rw` pulses the next cycle, and master 1 may use the bus that cycle.
- **m1 issue:** occurs in any cycle where `m0_act`=0 and the queue is non-empty.
  - The queue head drives `reg_*`: `reg_write`=we, `reg_read`=!we.
  - The head is popped at that edge.
- **Idle bus:** all `reg_*` outputs are 0.
- **Queue push:** on `m1_valid && m1_ready`.
  - `m1_ready` = (`m1_level` < DEPTH); it depends only on state, not on `m1_valid`.
  - Push and pop in the same cycle are allowed; `m1_level` stays unchanged.
- **Read response:** for an issued m1 read, `m1_rdata` <= `reg_rdata` at the issue edge, and `m1_rvalid` pulses for the following cycle. `m1_rdata` holds until the next read.
- **Writes:** no response.
- **Ordering:** commands issue strictly in order. Master-0 accesses interleave only between master-1 commands, never within one.
- **Same address, same cycle:** when m0 and the m1 head target the same address, m0 goes first and m1 issues later, so the m1 write is last-writer.
- **Head blocked:** while the head is blocked by `m0_act`, the head stays unchanged and `stall_cnt` increments, saturating at 255.

## Timing

- **Reset values:** queue empty, `m1_level`=0, `m1_ready`=1, `m1_rvalid`=0, `m1_rdata`=0, `stall_cnt`=0, `err_m0_rw`=0, all `reg_*`=0.
- **Reset mid-operation:** queued commands are discarded. A read issued in the reset cycle produces no `m1_rvalid`.
- **m0 latency:** 0 cycles; `m0_rdata` is valid in the strobe cycle.
- **m1 minimum latency:** command accepted at edge N → issued in cycle N+1 → `m1_rvalid` in cycle N+2.
- **Back-to-back:** one m1 issue per cycle maximum, so a full queue drains in DEPTH cycles with no m0 traffic.
- **Full queue:** `m1_ready` = 0. A pop at edge K raises `m1_ready` in cycle K+1.
- **Pointers:** wrap modulo DEPTH. Level arithmetic is $clog2(DEPTH+1) bits and never exceeds DEPTH.

## Structure

- **Package `reg_bus_pkg`:**
  - `ADDR_W`, `DATA_W` constants.
  - `reg_cmd_t` struct {we, addr, wdata}.
  - Saturation constant `STALL_MAX`=255.
- **Sub-module `reg_cmd_fifo`:** synchronous DEPTH-entry FIFO of `reg_cmd_t` with push, pop, head, level, full, empty.
- **Top level:** mux, issue logic, response register, counters.

## Test plan

- **Reset idle:** assert `rst` for 3 cycles, then release → all `reg_*`=0, `m1_ready`=1, `m1_level`=0, `stall_cnt`=0.
- **m0 pass-through:** `m0_write`, addr 0x13, data 0xA6 → same cycle `reg_write`=1, `reg_addr`=0x13, `reg_wdata`=0xA6. Then `m0_read` addr 0x01 with `reg_rdata`=0xEE → `m0_rdata`=0xEE in the same cycle.
- **m1 read latency:** push read addr 0x05 with `reg_rdata`=0x3C → `reg_read` in cycle N+1; `m1_rvalid`=1 and `m1_rdata`=0x3C in cycle N+2.
- **Collision:** m1 write addr 0x13 data 0x11 queued while m0 writes addr 0x13 data 0x22 → m0 issues first, m1 issues the next idle cycle, `stall_cnt`=1.
- **Queue full:** push 4 writes while m0 strobes every cycle → `m1_ready`=0 after the 4th, `m1_level`=4. When m0 stops, the writes drain in order over 4 cycles and `m1_ready`=1 after the first pop.
- **Illegal m0 and reset mid-operation:**
  - `m0_read`=`m0_write`=1 with a queued m1 write → the m1 write issues, `err_m0_rw` pulses the next cycle.
  - `rst` asserted with 3 queued commands → `m1_level`=0 and no subsequent `reg_*` activity.
